// File: rtl/video_stream_gen.sv
// Synthetic video source: de/h_sync/v_sync/mask stream with a programmable white rectangle.
// Rectangle config is double-buffered and only takes effect at frame boundaries.
module video_stream_gen #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int H_BLANK = 16,
    parameter int H_FP    = 4,
    parameter int HS_LEN  = 4,
    parameter int V_BLANK = 4,
    parameter int V_FP    = 1,
    parameter int VS_LEN  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [10:0] rect_x0,
    input  logic [10:0] rect_y0,
    input  logic [10:0] rect_w,
    input  logic [10:0] rect_h,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        mask_out,
    output logic [23:0] pixel_out,
    output logic        frame_start_out
);

    localparam int H_TOTAL = IMG_W + H_BLANK;
    localparam int V_TOTAL = IMG_H + V_BLANK;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [11:0] r_hCnt;
    logic [11:0] r_vCnt;
    logic        r_pending;
    logic [10:0] r_shX0, r_shY0, r_shW, r_shH;
    logic [10:0] r_actX0, r_actY0, r_actW, r_actH;

    logic        w_hWrap;
    logic        w_frameWrap;
    logic        w_origin;
    logic        w_run;
    logic        w_accept;
    logic        w_consume;
    logic [11:0] w_x0, w_y0, w_xEnd, w_yEnd;
    logic        w_de, w_hs, w_vs, w_mask;

    assign w_hWrap     = (r_hCnt == 12'(H_TOTAL - 1));
    assign w_frameWrap = w_hWrap && (r_vCnt == 12'(V_TOTAL - 1));
    assign w_origin    = (r_hCnt == 12'd0) && (r_vCnt == 12'd0);
    assign w_run       = (r_state != IDLE);
    assign w_accept    = cfg_valid && !r_pending;
    assign w_consume   = r_pending && w_origin;
    assign cfg_ready   = !r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:      if (enable) w_nextState = RUN;
            RUN, DRAIN: begin
                if (enable)           w_nextState = RUN;
                else if (w_frameWrap) w_nextState = IDLE;
                else                  w_nextState = DRAIN;
            end
            default:   w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (!w_run) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (w_hWrap) begin
            r_hCnt <= '0;
            r_vCnt <= (r_vCnt == 12'(V_TOTAL - 1)) ? 12'd0 : r_vCnt + 12'd1;
        end else begin
            r_hCnt <= r_hCnt + 12'd1;
        end
    end

    // The shadow is promoted while the counters sit at the origin, so the first pixel already uses it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_shX0 <= '0; r_shY0 <= '0; r_shW <= '0; r_shH <= '0;
            r_actX0 <= '0; r_actY0 <= '0; r_actW <= '0; r_actH <= '0;
        end else begin
            if (w_accept) begin
                r_pending <= 1'b1;
                r_shX0 <= rect_x0; r_shY0 <= rect_y0; r_shW <= rect_w; r_shH <= rect_h;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
            if (w_consume) begin
                r_actX0 <= r_shX0; r_actY0 <= r_shY0; r_actW <= r_shW; r_actH <= r_shH;
            end
        end
    end

    assign w_x0   = {1'b0, w_consume ? r_shX0 : r_actX0};
    assign w_y0   = {1'b0, w_consume ? r_shY0 : r_actY0};
    assign w_xEnd = w_x0 + {1'b0, w_consume ? r_shW : r_actW};
    assign w_yEnd = w_y0 + {1'b0, w_consume ? r_shH : r_actH};

    assign w_de   = (r_hCnt < 12'(IMG_W)) && (r_vCnt < 12'(IMG_H));
    assign w_hs   = (r_hCnt >= 12'(IMG_W + H_FP)) && (r_hCnt < 12'(IMG_W + H_FP + HS_LEN));
    assign w_vs   = (r_vCnt >= 12'(IMG_H + V_FP)) && (r_vCnt < 12'(IMG_H + V_FP + VS_LEN));
    assign w_mask = w_de && (r_hCnt >= w_x0) && (r_hCnt < w_xEnd)
                         && (r_vCnt >= w_y0) && (r_vCnt < w_yEnd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_out          <= 1'b0;
            h_sync_out      <= 1'b0;
            v_sync_out      <= 1'b0;
            mask_out        <= 1'b0;
            pixel_out       <= '0;
            frame_start_out <= 1'b0;
        end else begin
            de_out          <= w_run && w_de;
            h_sync_out      <= w_run && w_hs;
            v_sync_out      <= w_run && w_vs;
            mask_out        <= w_run && w_mask;
            pixel_out       <= {24{w_run && w_mask}};
            frame_start_out <= w_run && w_origin;
        end
    end

endmodule
